// File: rtl/layer0_input_loader.sv
// layer0_input_loader
// Streaming front-end for the first LUT layer of the autoencoder network.
// Raw signed features arrive one per beat, are quantized to a 2-bit code,
// packed into a shadow vector and then handed to an output register that
// holds the complete sample until the downstream layer accepts it.
//
// Optional feature macro: LOADER_THRESH_EN
//   defined   : code = (x >= T0) + (x >= T1) + (x >= T2), signed compares
//   undefined : code = offset-binary top two bits of x, no comparators built
module layer0_input_loader #(
  parameter int                     N_FEAT = 64,
  parameter int                     IN_W   = 8,
  parameter int                     CODE_W = 2,
  parameter logic signed [IN_W-1:0] T0     = IN_W'(-32),
  parameter logic signed [IN_W-1:0] T1     = IN_W'(0),
  parameter logic signed [IN_W-1:0] T2     = IN_W'(32)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [IN_W-1:0]          i_in_data,
  input  logic                     i_in_valid,
  input  logic                     i_in_last,
  output logic                     o_in_ready,
  output logic [N_FEAT*CODE_W-1:0] o_out_data,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic                     o_err
);

  localparam int VEC_W = N_FEAT * CODE_W;
  localparam int CNT_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N_FEAT - 1);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_XFER = 2'd1,
    S_SKIP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_in_ready;
  logic [VEC_W-1:0] r_shadow;
  logic [VEC_W-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_err;

  logic              w_beat;
  logic              w_last_slot;
  logic              w_slot_free;
  logic              w_shadow_we;
  logic              w_err_set;
  logic              w_load;
  logic [CODE_W-1:0] w_code;

  assign w_beat      = i_in_valid & r_in_ready;
  assign w_last_slot = (r_cnt == LAST_SLOT);
  assign w_slot_free = ~r_out_valid | i_out_ready;

`ifdef LOADER_THRESH_EN
  logic w_ge0;
  logic w_ge1;
  logic w_ge2;

  // Threshold quantizer: the code counts how many thresholds the feature reaches
  always_comb begin
    w_ge0  = ($signed(i_in_data) >= T0);
    w_ge1  = ($signed(i_in_data) >= T1);
    w_ge2  = ($signed(i_in_data) >= T2);
    w_code = CODE_W'(w_ge0) + CODE_W'(w_ge1) + CODE_W'(w_ge2);
  end
`else
  // Cheap quantizer: flipping the sign bit gives offset binary, keep its top two bits
  always_comb begin
    w_code = CODE_W'({~i_in_data[IN_W-1], i_in_data[IN_W-2]});
  end
`endif

  // Next-state logic: slot counting, framing error detection and the shadow-to-output hand-off
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_shadow_we  = 1'b0;
    w_err_set    = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      S_FILL: begin
        if (w_beat) begin
          w_shadow_we = 1'b1;
          if (w_last_slot) begin
            if (i_in_last) begin
              w_state_next = S_XFER;
            end else begin
              w_err_set    = 1'b1;
              w_cnt_next   = '0;
              w_state_next = S_SKIP;
            end
          end else if (i_in_last) begin
            w_err_set  = 1'b1;
            w_cnt_next = '0;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
      end
      S_XFER: begin
        if (w_slot_free) begin
          w_load       = 1'b1;
          w_cnt_next   = '0;
          w_state_next = S_FILL;
        end
      end
      S_SKIP: begin
        if (w_beat && i_in_last) begin
          w_cnt_next   = '0;
          w_state_next = S_FILL;
        end
      end
      default: begin
        w_cnt_next   = '0;
        w_state_next = S_FILL;
      end
    endcase
  end

  // State, slot counter and registered in_ready; in_ready is decoded from the next state so it never depends on out_ready combinationally
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_FILL;
      r_cnt      <= '0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_in_ready <= (w_state_next != S_XFER);
    end
  end

  // Shadow buffer: each accepted feature code lands in the slot selected by the counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shadow <= '0;
    end else if (w_shadow_we) begin
      r_shadow[r_cnt*CODE_W +: CODE_W] <= w_code;
    end
  end

  // Output register: a reload from the shadow wins over the downstream handshake clearing valid
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_data  <= r_shadow;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky framing error flag, cleared only by reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_err       = r_err;

endmodule

// File: tb/tb_layer0_input_loader.sv
// tb_layer0_input_loader
// Self-checking bench for layer0_input_loader with N_FEAT = 4.
// A sample-level reference model (lists of codes, skip flag, sticky error)
// predicts which packed vectors must appear on the output and in what order.
// Honours LOADER_THRESH_EN in its reference quantizer.
module tb_layer0_input_loader;

  localparam int N_FEAT = 4;
  localparam int IN_W   = 8;
  localparam int CODE_W = 2;
  localparam int VEC_W  = N_FEAT * CODE_W;

  logic             clk;
  logic             rst;
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [VEC_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             err;

  int checks;
  int errors;

  logic [VEC_W-1:0] exp_q[$];
  logic [VEC_W-1:0] obs_q[$];
  logic [1:0]       mdl_codes[$];
  bit               mdl_skip;
  bit               mdl_err;
  bit               bp_random;

  layer0_input_loader #(
    .N_FEAT(N_FEAT),
    .IN_W  (IN_W),
    .CODE_W(CODE_W)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_in_data  (in_data),
    .i_in_valid (in_valid),
    .i_in_last  (in_last),
    .o_in_ready (in_ready),
    .o_out_data (out_data),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor: records every vector handed downstream, sampled mid-cycle
  always begin
    @(negedge clk);
    #2;
    if (!rst && out_valid && out_ready) obs_q.push_back(out_data);
  end

  // Random backpressure generator used by the randomized stream test
  always @(negedge clk) begin
    if (bp_random) out_ready = 1'($urandom_range(0, 1));
  end

  // Reference quantizer written from the arithmetic definition of the code
  function automatic logic [1:0] ref_code(input logic [IN_W-1:0] raw);
    int x;
    int c;
    x = int'($signed(raw));
    c = 0;
`ifdef LOADER_THRESH_EN
    if (x >= -32) c++;
    if (x >= 0)   c++;
    if (x >= 32)  c++;
`else
    c = (x + 128) / 64;
`endif
    return 2'(c);
  endfunction

  // Sample-level framing model: collects codes, drops malformed samples
  task automatic model_beat(input logic [IN_W-1:0] d, input logic l);
    logic [VEC_W-1:0] v;
    if (mdl_skip) begin
      if (l) mdl_skip = 1'b0;
    end else begin
      mdl_codes.push_back(ref_code(d));
      if (mdl_codes.size() == N_FEAT) begin
        if (l) begin
          v = '0;
          for (int i = 0; i < N_FEAT; i++) v[2*i +: 2] = mdl_codes[i];
          exp_q.push_back(v);
        end else begin
          mdl_err  = 1'b1;
          mdl_skip = 1'b1;
        end
        mdl_codes.delete();
      end else if (l) begin
        mdl_err = 1'b1;
        mdl_codes.delete();
      end
    end
  endtask

  task automatic model_reset();
    mdl_codes.delete();
    exp_q.delete();
    obs_q.delete();
    mdl_skip = 1'b0;
    mdl_err  = 1'b0;
  endtask

  // Drive one beat from a falling edge and wait, bounded, until it is accepted
  task automatic send_beat(input logic [IN_W-1:0] d, input logic l);
    bit   done;
    logic rdy;
    done     = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = l;
    for (int n = 0; n < 200 && !done; n++) begin
      rdy = in_ready;
      @(posedge clk);
      @(negedge clk);
      if (rdy === 1'b1) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL beat_accept: got timeout required acceptance of %h", d);
    end else begin
      model_beat(d, l);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_random_sample(input bit with_last);
    for (int i = 0; i < N_FEAT; i++) send_beat(8'($urandom), (i == N_FEAT - 1) && with_last);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    bp_random = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b required 0", err); end
    checks++;
    if (out_data !== '0) begin errors++; $display("[TB] FAIL reset_out_data: got %h required 00", out_data); end
  endtask

  task automatic test_basic();
    logic [IN_W-1:0] vals[N_FEAT];
`ifdef LOADER_THRESH_EN
    vals = '{8'hDF, 8'hE0, 8'h00, 8'h20};
`else
    vals = '{8'h80, 8'hC0, 8'h00, 8'h7F};
`endif
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < N_FEAT; i++) send_beat(vals[i], i == N_FEAT - 1);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL basic_xfer_ready: got %b required 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_xfer_valid: got %b required 0", out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: got %b required 1", out_valid); end
    checks++;
    if (out_data !== 8'b11_10_01_00) begin errors++; $display("[TB] FAIL basic_data: got %b required 11100100", out_data); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready_back: got %b required 1", in_ready); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_one_cycle: got %b required 0", out_valid); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("[TB] FAIL basic_err: got %b required 0", err); end
    checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      errors++;
      $display("[TB] FAIL basic_stream: got %0d vectors required %0d", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    send_random_sample(1'b1);
    send_random_sample(1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
      errors++;
      $display("[TB] FAIL bp_hold_a: got %b/%h required 1/%h", out_valid, out_data, exp_q[0]);
    end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_stall_ready: got %b required 0", in_ready); end
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_data !== exp_q[0]) begin
      errors++;
      $display("[TB] FAIL bp_still_stalled: got %b/%h required 0/%h", in_ready, out_data, exp_q[0]);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_handover_valid: got %b required 1", out_valid); end
    checks++;
    if (out_data !== exp_q[1]) begin errors++; $display("[TB] FAIL bp_handover_data: got %h required %h", out_data, exp_q[1]); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_back: got %b required 1", in_ready); end
    @(negedge clk);
    checks++;
    if (out_data !== exp_q[1] || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_stable_b: got %b/%h required 1/%h", out_valid, out_data, exp_q[1]);
    end
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
      errors++;
      $display("[TB] FAIL bp_order: got %0d vectors required %0d in order", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_early_last();
    do_reset();
    out_ready = 1'b1;
    send_beat(8'($urandom), 1'b0);
    send_beat(8'($urandom), 1'b1);
    checks++;
    if (err !== 1'b1) begin errors++; $display("[TB] FAIL early_err: got %b required 1", err); end
    repeat (2) @(negedge clk);
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL early_no_output: got %0d vectors required 0", obs_q.size()); end
    send_random_sample(1'b1);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
      errors++;
      $display("[TB] FAIL early_next_sample: got %b/%h required 1/%h", out_valid, out_data, exp_q[0]);
    end
    checks++;
    if (err !== 1'b1) begin errors++; $display("[TB] FAIL early_err_sticky: got %b required 1", err); end
  endtask

  task automatic test_missing_last();
    do_reset();
    out_ready = 1'b1;
    send_random_sample(1'b0);
    checks++;
    if (err !== 1'b1) begin errors++; $display("[TB] FAIL missing_err: got %b required 1", err); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL missing_skip_ready: got %b required 1", in_ready); end
    send_beat(8'($urandom), 1'b0);
    send_beat(8'($urandom), 1'b0);
    send_beat(8'($urandom), 1'b1);
    send_random_sample(1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size() || obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      errors++;
      $display("[TB] FAIL missing_following: got %0d vectors required %0d", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_beat(8'($urandom), 1'b1);
    send_random_sample(1'b1);
    send_beat(8'($urandom), 1'b0);
    send_beat(8'($urandom), 1'b0);
    checks++;
    if (out_valid !== 1'b1 || err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rstmid_pre: got valid %b err %b required 1 1", out_valid, err);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid: got %b required 0", out_valid); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_err: got %b required 0", err); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_ready: got %b required 1", in_ready); end
    out_ready = 1'b1;
    send_random_sample(1'b1);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
      errors++;
      $display("[TB] FAIL rstmid_fresh: got %b/%h required 1/%h", out_valid, out_data, exp_q[0]);
    end
  endtask

  task automatic test_random_stream();
    int kind;
    int n;
    do_reset();
    bp_random = 1'b1;
    for (int s = 0; s < 30; s++) begin
      kind = $urandom_range(0, 7);
      if (kind == 0) begin
        n = $urandom_range(1, N_FEAT - 1);
        for (int i = 0; i < n; i++) send_beat(8'($urandom), i == n - 1);
      end else if (kind == 1) begin
        send_random_sample(1'b0);
      end else begin
        for (int i = 0; i < N_FEAT; i++) begin
          send_beat(8'($urandom), i == N_FEAT - 1);
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
        end
      end
    end
    @(negedge clk);
    bp_random = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL rand_count: got %0d vectors required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL rand_vec%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (err !== mdl_err) begin errors++; $display("[TB] FAIL rand_err: got %b required %b", err, mdl_err); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rand_drained: got %b required 0", out_valid); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    bp_random = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_reset_mid();
    test_random_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer0_input_loader.md
# layer0_input_loader

Streaming front-end for the first LUT layer of the autoencoder network. It accepts one raw signed feature per beat over a valid/ready handshake and quantizes each feature to a 2-bit code. It packs the codes of one complete sample into the flat input vector consumed by the layer-0 neuron LUTs, then holds that vector in an output register until the downstream layer pipeline accepts it. A shadow buffer lets the next sample be collected while the current vector waits.

## Interface
- N_FEAT, 64: features per sample; must be ≥ 2.
- IN_W, 8: raw feature width, two's complement.
- CODE_W, 2: quantized code width (fixed at 2; the parameter exists for port sizing only).
- T0, T1, T2, -32 / 0 / 32: signed IN_W-bit thresholds, T0 < T1 < T2. Used only with LOADER_THRESH_EN.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  IN_W  raw feature.
- in_valid  in  1  in_data is valid.
- in_last  in  1  marks the final feature of a sample.
- in_ready  out  1  loader accepts a beat this cycle.
- out_data  out  N_FEAT*CODE_W  packed codes; feature i occupies bits [2i+1:2i].
- out_valid  out  1  out_data holds a complete sample.
- out_ready  in  1  downstream accepts out_data.
- err  out  1  sticky framing error.

## Operation
- Beat accepted ⇔ in_valid & in_ready.
- FSM states:
  - FILL: in_ready = 1.
    - Accepted beat: code written to shadow slot cnt.
    - If cnt == N_FEAT-1 and in_last = 1 → XFER, cnt holds.
    - Otherwise cnt increments.
  - XFER: in_ready = 0.
    - Slot free (!out_valid | out_ready) → out_data ← shadow, out_valid ← 1, cnt ← 0, go to FILL.
    - Slot not free → stay in XFER.
  - SKIP: in_ready = 1; beats are discarded.
    - Accepted beat with in_last = 1 → cnt ← 0, go to FILL.
- Framing errors:
  - in_last = 1 on an accepted beat with cnt < N_FEAT-1: err ← 1; partial sample dropped; cnt ← 0; stay in FILL.
  - in_last = 0 on the beat with cnt == N_FEAT-1: err ← 1; go to SKIP; the sample is dropped.
- out_valid clears on out_valid & out_ready unless it is reloaded from XFER in the same cycle. The reload wins, so back-to-back samples are possible.
- out_data is stable while out_valid = 1 and out_ready = 0.
- err clears only on rst.
- Reset values: state = FILL, cnt = 0, out_valid = 0, out_data = 0, err = 0, shadow = 0. in_ready = 1 from the first cycle after reset.
- Reset mid-sample discards the partial shadow and any pending output without emitting it.

## Timing
- Last beat accepted at edge k → XFER during cycle k+1.
- If the slot is free, out_valid = 1 from edge k+1: 1-cycle latency from the last beat to the output.
- If out_valid is held by backpressure, transfer occurs on the first edge where out_ready = 1. out_valid stays 1 across the handover, and out_data updates on that edge.
- Sustained throughput: N_FEAT beats per N_FEAT+1 cycles, because in_ready drops for exactly one cycle per sample when the output is not stalled.
- in_ready is a registered function of state only, with no combinational path from out_ready.
- Quantization is purely combinational on in_data and registered into shadow on acceptance. No extra latency.

## Configuration
- LOADER_THRESH_EN defined:
  - code = (x ≥ T0) + (x ≥ T1) + (x ≥ T2), signed compares; result range 0..3.
- LOADER_THRESH_EN undefined:
  - code = {~x[IN_W-1], x[IN_W-2]}, i.e. the offset-binary top two bits.
  - Threshold parameters are ignored and no comparators are built.

## Test plan
- N_FEAT=4, no macro: send 0x80, 0xC0, 0x00, 0x7F with in_last on the 4th beat, out_ready=1 → out_data = 8'b11_10_01_00, out_valid for 1 cycle, err = 0.
- LOADER_THRESH_EN, defaults: features -33, -32, 0, 32 → codes 0, 1, 2, 3 → out_data = 8'b11_10_01_00.
- Backpressure: hold out_ready = 0; stream sample A, then sample B → in_ready = 0 after B completes. Raise out_ready for 1 cycle → out_data switches from A to B on that edge and out_valid stays 1.
- Early in_last on beat 2 of 4 → err = 1, no output. The next 4-beat sample is emitted correctly.
- Missing in_last on beat 4 → err = 1; SKIP discards beats until in_last. The following sample is emitted intact.
- Assert rst after 2 beats and while out_valid = 1 → next cycle out_valid = 0, err = 0, in_ready = 1. A fresh sample produces correct output.
